plru_alloc_ctrl: RTL and testbench

Allocation controller for a small fully-associative structure (TLB, fill buffer, victim cache) with ENTRY_COUNT entries. It owns the pseudo-LRU tree state and serialises allocation requests through a valid/ready handshake. Victim choice order is: a free entry first, then the PLRU victim, skipping locked and in-flight entries. It also absorbs lookup-hit touches every cycle and holds each granted entry as pending until its fill completes.

---
 rtl/plru_alloc_pkg.sv | 58 +++++
 rtl/plru_alloc_ctrl_victim_sel.sv | 42 ++++
 rtl/plru_alloc_ctrl.sv | 134 +++++++++++++
 tb/tb_plru_alloc_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_alloc_pkg.sv
// Shared types and tree helpers for the PLRU allocation controller.
// Node vectors are handled at a fixed maximum width so one set of functions serves every ENTRY_COUNT.
package plru_alloc_pkg;

  localparam int unsigned MAX_ENTRIES = 64;
  localparam int unsigned MAX_LEVELS  = 6;
  localparam int unsigned MAX_NODES   = MAX_ENTRIES - 1;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    GRANT,
    FILL
  } alloc_state_e;

  typedef logic [MAX_NODES-1:0] plru_nodes_t;

  function automatic int unsigned node_count(input int unsigned entries);
    return entries - 1;
  endfunction

  // Walk idx's path from the root and make every node point to the other subtree.
  function automatic plru_nodes_t plru_update(input plru_nodes_t nodes,
                                              input int unsigned idx,
                                              input int unsigned levels);
    plru_nodes_t upd;
    int unsigned k;
    logic        dir;
    upd = nodes;
    k   = 0;
    for (int unsigned l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        dir = ((idx >> (levels - 1 - l)) & 32'd1) != 0;
        upd = (upd & ~(plru_nodes_t'(1) << k)) | (plru_nodes_t'(!dir) << k);
        k   = (k << 1) + 32'd1 + 32'(dir);
      end
    end
    return upd;
  endfunction

  function automatic int unsigned plru_victim(input plru_nodes_t nodes,
                                              input int unsigned levels);
    int unsigned k;
    int unsigned idx;
    plru_nodes_t sh;
    k   = 0;
    idx = 0;
    for (int unsigned l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        sh  = nodes >> k;
        idx = (idx << 1) | 32'(sh[0]);
        k   = (k << 1) + 32'd1 + 32'(sh[0]);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/plru_alloc_ctrl_victim_sel.sv
// Combinational PLRU tree: next node state from touch and grant, and the current victim.
// A same-cycle grant is applied after the touch so the victim path wins at shared nodes.
module plru_victim_sel
  import plru_alloc_pkg::*;
#(
  parameter  int unsigned ENTRY_COUNT = 8,
  localparam int unsigned NODE_W      = ENTRY_COUNT - 1
) (
  input  logic [NODE_W-1:0]      node_q,
  input  logic [ENTRY_COUNT-1:0] touch_mask,
  input  logic [ENTRY_COUNT-1:0] grant_mask,
  output logic [NODE_W-1:0]      node_d,
  output logic [ENTRY_COUNT-1:0] victim_mask
);

  localparam int unsigned LEVELS = $clog2(ENTRY_COUNT);

  logic [NODE_W-1:0] node_touched;
  int unsigned       touch_idx;
  int unsigned       grant_idx;
  int unsigned       victim_idx;

  always_comb begin
    touch_idx = 0;
    grant_idx = 0;
    for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
      if (touch_mask[i]) touch_idx = i;
      if (grant_mask[i]) grant_idx = i;
    end

    node_touched = (|touch_mask)
                 ? NODE_W'(plru_update(MAX_NODES'(node_q), touch_idx, LEVELS))
                 : node_q;
    node_d       = (|grant_mask)
                 ? NODE_W'(plru_update(MAX_NODES'(node_touched), grant_idx, LEVELS))
                 : node_touched;

    victim_idx  = plru_victim(MAX_NODES'(node_q), LEVELS);
    victim_mask = ENTRY_COUNT'(1) << victim_idx;
  end

endmodule

// File: rtl/plru_alloc_ctrl.sv
// Allocation controller: serialises requests, picks a victim (free, then PLRU, then lowest
// eligible), holds it until taken, and keeps it pending until its fill completes.
module plru_alloc_ctrl
  import plru_alloc_pkg::*;
#(
  parameter  int unsigned ENTRY_COUNT = 8,
  localparam int unsigned IDX_W       = $clog2(ENTRY_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [ENTRY_COUNT-1:0] touch_mask_i,
  input  logic [ENTRY_COUNT-1:0] entry_valid_i,
  input  logic [ENTRY_COUNT-1:0] lock_mask_i,
  input  logic                   alloc_req_valid_i,
  output logic                   alloc_req_ready_o,
  output logic                   alloc_rsp_valid_o,
  input  logic                   alloc_rsp_ready_i,
  output logic [ENTRY_COUNT-1:0] alloc_rsp_mask_o,
  output logic [IDX_W-1:0]       alloc_rsp_idx_o,
  input  logic                   fill_done_i,
  output logic                   alloc_stall_o,
  output logic                   busy_o
);

  localparam int unsigned NODE_W = node_count(ENTRY_COUNT);

  alloc_state_e state_q, state_d;

  logic [NODE_W-1:0]      node_q, node_d;
  logic [ENTRY_COUNT-1:0] pending_q;
  logic [ENTRY_COUNT-1:0] rsp_mask_q;
  logic [IDX_W-1:0]       rsp_idx_q;
  logic [ENTRY_COUNT-1:0] victim_mask;
  logic [ENTRY_COUNT-1:0] grant_mask;
  logic [ENTRY_COUNT-1:0] eligible;
  logic [ENTRY_COUNT-1:0] free;
  logic [ENTRY_COUNT-1:0] pick_mask;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       elig_idx;
  logic [IDX_W-1:0]       victim_idx;
  logic                   free_hit;
  logic                   elig_hit;
  logic                   pick_found;
  logic                   grant_hs;

  assign grant_hs   = (state_q == GRANT) && alloc_rsp_ready_i;
  assign grant_mask = grant_hs ? rsp_mask_q : '0;

  plru_victim_sel #(
    .ENTRY_COUNT(ENTRY_COUNT)
  ) u_victim_sel (
    .node_q     (node_q),
    .touch_mask (touch_mask_i),
    .grant_mask (grant_mask),
    .node_d     (node_d),
    .victim_mask(victim_mask)
  );

  always_comb begin
    eligible   = ~lock_mask_i & ~pending_q;
    free       = eligible & ~entry_valid_i;
    free_hit   = 1'b0;
    elig_hit   = 1'b0;
    free_idx   = '0;
    elig_idx   = '0;
    victim_idx = '0;
    for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
      if (free[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (eligible[i] && !elig_hit) begin
        elig_hit = 1'b1;
        elig_idx = IDX_W'(i);
      end
      if (victim_mask[i]) victim_idx = IDX_W'(i);
    end

    if (free_hit)                        pick_idx = free_idx;
    else if (|(victim_mask & eligible))  pick_idx = victim_idx;
    else                                 pick_idx = elig_idx;

    pick_found = elig_hit;
    pick_mask  = pick_found ? (ENTRY_COUNT'(1) << pick_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (alloc_req_valid_i) state_d = SELECT;
      SELECT:  if (pick_found)        state_d = GRANT;
      GRANT:   if (alloc_rsp_ready_i) state_d = FILL;
      FILL:    if (fill_done_i)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alloc_req_ready_o = (state_q == IDLE) && !flush_i;
    alloc_rsp_valid_o = (state_q == GRANT);
    alloc_stall_o     = (state_q == SELECT) && !pick_found;
    busy_o            = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      node_q     <= '0;
      pending_q  <= '0;
      rsp_mask_q <= '0;
      rsp_idx_q  <= '0;
    end else begin
      node_q <= node_d;
      if (state_q == SELECT && pick_found) begin
        rsp_mask_q <= pick_mask;
        rsp_idx_q  <= pick_idx;
      end
      if (grant_hs)                          pending_q <= rsp_mask_q;
      else if (state_q == FILL && fill_done_i) pending_q <= '0;
    end
  end

  assign alloc_rsp_mask_o = rsp_mask_q;
  assign alloc_rsp_idx_o  = rsp_idx_q;

  touch_onehot0_a: assert property (@(posedge clk) disable iff (rst) $onehot0(touch_mask_i));

endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// Bench for plru_alloc_ctrl with four entries: directed scenarios followed by randomized
// allocations, checked against a heap-indexed PLRU reference model.
module tb_plru_alloc_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned LV = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N-1:0]  touch;
  logic [N-1:0]  valid;
  logic [N-1:0]  lock;
  logic          req_valid;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_mask;
  logic [LV-1:0] rsp_idx;
  logic          fill_done;
  logic          stall;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [N-2:0] mnodes;

  always #5 clk = ~clk;

  plru_alloc_ctrl #(.ENTRY_COUNT(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .touch_mask_i     (touch),
    .entry_valid_i    (valid),
    .lock_mask_i      (lock),
    .alloc_req_valid_i(req_valid),
    .alloc_req_ready_o(req_ready),
    .alloc_rsp_valid_o(rsp_valid),
    .alloc_rsp_ready_i(rsp_ready),
    .alloc_rsp_mask_o (rsp_mask),
    .alloc_rsp_idx_o  (rsp_idx),
    .fill_done_i      (fill_done),
    .alloc_stall_o    (stall),
    .busy_o           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Level l of the tree starts at heap slot 2^l-1; the index prefix selects the node.
  function automatic logic [N-2:0] m_access(input logic [N-2:0] t, input int i);
    for (int l = 0; l < LV; l++) begin
      int pos = (1 << l) - 1 + (i >> (LV - l));
      t[pos] = ((i >> (LV - 1 - l)) & 1) == 0;
    end
    return t;
  endfunction

  function automatic int m_victim(input logic [N-2:0] t);
    int p = 0;
    for (int l = 0; l < LV; l++) p = 2 * p + int'(t[(1 << l) - 1 + p]);
    return p;
  endfunction

  function automatic int m_pick(input logic [N-1:0] v, input logic [N-1:0] lk);
    int first_free = -1;
    int first_el   = -1;
    int vic        = m_victim(mnodes);
    for (int i = 0; i < N; i++) begin
      if (!lk[i]) begin
        if (first_el < 0) first_el = i;
        if (!v[i] && first_free < 0) first_free = i;
      end
    end
    if (first_free >= 0) return first_free;
    if (!lk[vic]) return vic;
    return first_el;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] m);
    int r = 0;
    for (int i = 0; i < N; i++) if (m[i]) r = i;
    return r;
  endfunction

  function automatic logic [N-1:0] rnd_touch();
    int r = int'($urandom_range(0, N));
    return (r == 0) ? '0 : (N'(1) << (r - 1));
  endfunction

  task automatic clk_edge(input bit g, input int gi);
    logic [N-1:0] t;
    logic fl;
    logic rs;
    @(posedge clk);
    t  = touch;
    fl = flush;
    rs = rst;
    if (rs || fl) mnodes = '0;
    else begin
      if (t != '0) mnodes = m_access(mnodes, oh_idx(t));
      if (g)       mnodes = m_access(mnodes, gi);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; touch = '0; valid = '1; lock = '0;
    req_valid = 1'b0; rsp_ready = 1'b0; fill_done = 1'b0;
    clk_edge(0, 0);
    clk_edge(0, 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic alloc(input string tag, input logic [N-1:0] v, input logic [N-1:0] lk,
                       input logic [N-1:0] rel, input bit rt, input int hold, input bit sib);
    int exp;
    valid = v; lock = lk; touch = rt ? rnd_touch() : '0; req_valid = 1'b1;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 1);
    clk_edge(0, 0);
    req_valid = 1'b0; touch = rt ? rnd_touch() : '0;
    #1;
    chk({tag, ".sel_busy"}, 32'(busy), 1);
    chk({tag, ".sel_rsp_valid"}, 32'(rsp_valid), 0);
    exp = m_pick(v, lk);
    if (exp < 0) begin
      chk({tag, ".stall"}, 32'(stall), 1);
      clk_edge(0, 0);
      chk({tag, ".stall_hold"}, 32'(stall), 1);
      chk({tag, ".stall_no_rsp"}, 32'(rsp_valid), 0);
      lock = rel;
      #1;
      exp = m_pick(v, rel);
    end
    chk({tag, ".no_stall"}, 32'(stall), 0);
    clk_edge(0, 0);
    touch = '0;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
    chk({tag, ".rsp_idx"}, 32'(rsp_idx), 32'(exp));
    chk({tag, ".rsp_mask"}, 32'(rsp_mask), 32'(1) << exp);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0; lock = N'($urandom_range(0, (1 << N) - 1));
      touch = rt ? rnd_touch() : '0;
      clk_edge(0, 0);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 1);
      chk({tag, ".hold_idx"}, 32'(rsp_idx), 32'(exp));
      chk({tag, ".hold_mask"}, 32'(rsp_mask), 32'(1) << exp);
    end
    rsp_ready = 1'b1;
    touch = sib ? (N'(1) << (exp ^ 1)) : (rt ? rnd_touch() : '0);
    clk_edge(1, exp);
    rsp_ready = 1'b0; touch = '0;
    chk({tag, ".fill_nodes"}, 32'(dut.node_q), 32'(mnodes));
    chk({tag, ".fill_pending"}, 32'(dut.pending_q), 32'(1) << exp);
    chk({tag, ".fill_busy"}, 32'(busy), 1);
    chk({tag, ".fill_rsp_valid"}, 32'(rsp_valid), 0);
    fill_done = 1'b1;
    clk_edge(0, 0);
    fill_done = 1'b0;
    chk({tag, ".done_busy"}, 32'(busy), 0);
    chk({tag, ".done_pending"}, 32'(dut.pending_q), 0);
    chk({tag, ".done_nodes"}, 32'(dut.node_q), 32'(mnodes));
  endtask

  task automatic flush_in(input string tag, input bit in_fill);
    int exp;
    valid = '1; lock = '0; touch = '0; req_valid = 1'b1;
    clk_edge(0, 0);
    req_valid = 1'b0;
    exp = m_pick(valid, lock);
    clk_edge(0, 0);
    chk({tag, ".pre_rsp_valid"}, 32'(rsp_valid), 1);
    if (in_fill) begin
      rsp_ready = 1'b1;
      clk_edge(1, exp);
      rsp_ready = 1'b0;
      chk({tag, ".pre_pending"}, 32'(dut.pending_q), 32'(1) << exp);
    end
    flush = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1; touch = rnd_touch();
    #1;
    chk({tag, ".ready_low"}, 32'(req_ready), 0);
    clk_edge(0, 0);
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; touch = '0;
    #1;
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".pending"}, 32'(dut.pending_q), 0);
    chk({tag, ".nodes"}, 32'(dut.node_q), 32'(mnodes));
    chk({tag, ".ready"}, 32'(req_ready), 1);
  endtask

  initial begin
    mnodes = '0;
    do_reset();
    chk("rst.ready", 32'(req_ready), 1);
    chk("rst.rsp_valid", 32'(rsp_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.mask", 32'(rsp_mask), 0);
    chk("rst.idx", 32'(rsp_idx), 0);
    chk("rst.nodes", 32'(dut.node_q), 0);

    alloc("plru_a", '1, '0, '0, 0, 0, 0);
    alloc("plru_b", '1, '0, '0, 0, 0, 0);

    touch = 4'b0001; clk_edge(0, 0);
    touch = 4'b0100; clk_edge(0, 0);
    touch = '0;
    chk("touch.nodes", 32'(dut.node_q), 32'(mnodes));
    alloc("touch", '1, '0, '0, 0, 0, 0);

    do_reset();
    alloc("free", 4'b1011, '0, '0, 0, 0, 0);
    do_reset();
    alloc("locked_victim", '1, 4'b0001, '0, 0, 0, 0);
    alloc("stall", '1, 4'b1111, 4'b1011, 0, 0, 0);
    alloc("grant_hold", '1, '0, '0, 0, 5, 1);

    flush_in("flush_grant", 0);
    flush_in("flush_fill", 1);

    for (int n = 0; n < 40; n++) begin
      logic [N-1:0] v;
      logic [N-1:0] lk;
      logic [N-1:0] rel;
      v   = N'($urandom_range(0, (1 << N) - 1));
      lk  = N'($urandom_range(0, (1 << N) - 1));
      rel = lk & ~(N'(1) << $urandom_range(0, N - 1));
      alloc("rand", v, lk, rel, 1, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      lock = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
